// File: rtl/checkpoint_tag_manager.sv
// checkpoint_tag_manager: age-ordered branch checkpoint slots with mispredict recall and drain sequencing
module checkpoint_tag_manager #(
    parameter int NUM_CP         = 4,
    parameter int AL_IDX_W       = 5,
    parameter int NUM_RES        = 2,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_req,
    input  logic [AL_IDX_W-1:0]           alloc_al_idx,
    output logic                          alloc_gnt,
    output logic [$clog2(NUM_CP)-1:0]     alloc_tag,
    input  logic [NUM_RES-1:0]            resolve_valid,
    input  logic [NUM_RES*AL_IDX_W-1:0]   resolve_al_idx,
    input  logic [NUM_RES-1:0]            resolve_correct,
    output logic                          recall_start,
    output logic [$clog2(NUM_CP)-1:0]     recall_tag,
    output logic                          recover_busy,
    output logic                          cp_full,
    output logic [$clog2(NUM_CP+1)-1:0]   live_count,
    output logic                          int_stall
);
    localparam int TW = $clog2(NUM_CP);
    localparam int CW = $clog2(NUM_CP + 1);
    localparam int DW = $clog2(RECOVER_CYCLES + 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECALL = 2'd1;
    localparam logic [1:0] DRAIN  = 2'd2;

    logic [NUM_CP-1:0]   valid_q, valid_d, resolved_q, resolved_d, mis_slot, cor_slot;
    logic [AL_IDX_W-1:0] al_q [NUM_CP];
    logic [AL_IDX_W-1:0] al_d [NUM_CP];
    logic [TW-1:0]       head_q, head_d, tail_q, tail_d, recall_tag_q, recall_tag_d, mis_tag, slot;
    logic [CW-1:0]       count_q, count_d, mis_age;
    logic [1:0]          state_q, state_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                recall_start_q, recall_start_d, mispredict, retire;

    always_comb begin
        mis_slot = '0;
        cor_slot = '0;
        for (int s = 0; s < NUM_CP; s++)
            for (int i = 0; i < NUM_RES; i++)
                if (resolve_valid[i] && valid_q[s] && al_q[s] == resolve_al_idx[i*AL_IDX_W +: AL_IDX_W]) begin
                    cor_slot[s] = cor_slot[s] | resolve_correct[i];
                    mis_slot[s] = mis_slot[s] | ~resolve_correct[i];
                end
        // Scan youngest to oldest so the oldest mispredicting slot is left selected
        slot    = '0;
        mis_tag = head_q;
        mis_age = '0;
        for (int a = NUM_CP - 1; a >= 0; a--) begin
            slot = head_q + TW'(a);
            if (mis_slot[slot]) begin
                mis_tag = slot;
                mis_age = CW'(a);
            end
        end
        mispredict = |mis_slot;
        retire     = valid_q[head_q] & resolved_q[head_q];
        alloc_gnt  = alloc_req && state_q == IDLE && !cp_full && !mispredict;
        valid_d    = valid_q;
        resolved_d = resolved_q | cor_slot;
        al_d       = al_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (mispredict) begin
            for (int a = 0; a < NUM_CP; a++) begin
                slot = head_q + TW'(a);
                if (CW'(a) >= mis_age) begin
                    valid_d[slot]    = 1'b0;
                    resolved_d[slot] = 1'b0;
                end
            end
            tail_d  = mis_tag;
            count_d = mis_age;
        end else begin
            if (retire) begin
                valid_d[head_q]    = 1'b0;
                resolved_d[head_q] = 1'b0;
                head_d             = head_q + 1'b1;
            end
            if (alloc_gnt) begin
                valid_d[tail_q]    = 1'b1;
                resolved_d[tail_q] = 1'b0;
                al_d[tail_q]       = alloc_al_idx;
                tail_d             = tail_q + 1'b1;
            end
            count_d = count_q + CW'(alloc_gnt) - CW'(retire);
        end
        state_d = mispredict ? RECALL :
                  state_q == RECALL ? DRAIN :
                  (state_q == DRAIN && drain_q == DW'(RECOVER_CYCLES - 1)) ? IDLE : state_q;
        drain_d        = (state_q == DRAIN && !mispredict) ? drain_q + 1'b1 : '0;
        recall_start_d = mispredict;
        recall_tag_d   = mispredict ? mis_tag : recall_tag_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q        <= '0;
            resolved_q     <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            state_q        <= IDLE;
            drain_q        <= '0;
            recall_start_q <= 1'b0;
            recall_tag_q   <= '0;
        end else begin
            valid_q        <= valid_d;
            resolved_q     <= resolved_d;
            al_q           <= al_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            state_q        <= state_d;
            drain_q        <= drain_d;
            recall_start_q <= recall_start_d;
            recall_tag_q   <= recall_tag_d;
        end
    end

    assign alloc_tag    = tail_q;
    assign recall_start = recall_start_q;
    assign recall_tag   = recall_tag_q;
    assign recover_busy = state_q != IDLE;
    assign cp_full      = count_q == CW'(NUM_CP);
    assign live_count   = count_q;
    assign int_stall    = (alloc_req & ~alloc_gnt) | recover_busy;
endmodule

// File: tb/tb_checkpoint_tag_manager.sv
// tb_checkpoint_tag_manager: randomized scoreboard bench against a queue-based checkpoint model
module tb_checkpoint_tag_manager;
    localparam int NCP = 4;
    localparam int RC  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       alloc_req = 1'b0;
    logic [4:0] alloc_al_idx = '0;
    logic       alloc_gnt;
    logic [1:0] alloc_tag;
    logic [1:0] resolve_valid = '0;
    logic [9:0] resolve_al_idx = '0;
    logic [1:0] resolve_correct = '0;
    logic       recall_start;
    logic [1:0] recall_tag;
    logic       recover_busy, cp_full, int_stall;
    logic [2:0] live_count;

    checkpoint_tag_manager #(.NUM_CP(NCP), .AL_IDX_W(5), .NUM_RES(2), .RECOVER_CYCLES(RC)) dut (
        .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_al_idx(alloc_al_idx),
        .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag), .resolve_valid(resolve_valid),
        .resolve_al_idx(resolve_al_idx), .resolve_correct(resolve_correct),
        .recall_start(recall_start), .recall_tag(recall_tag), .recover_busy(recover_busy),
        .cp_full(cp_full), .live_count(live_count), .int_stall(int_stall)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] al; bit res; int slot; } ent_t;
    typedef struct { bit gnt; int tag; bit stall; bit busy; bit full; int live; bit rs; int rt; } st_t;

    // Model: live checkpoints in age order (index 0 = oldest)
    ent_t mq[$];
    int   m_tail, m_busy_left, m_rt;
    bit   m_rs;
    st_t  st_q[$];
    int   gnt_q[$];
    int   rc_q[$];
    int   errors = 0;
    int   checks = 0;
    logic [4:0] t1al [4] = '{5'd3, 5'd7, 5'd9, 5'd12};

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_tail = 0;
        m_busy_left = 0;
        m_rs = 0;
        m_rt = 0;
    endtask

    task automatic step(input bit rq, input logic [4:0] al, input bit [1:0] rv,
                        input logic [4:0] a0, input logic [4:0] a1, input bit [1:0] rc, input bit rn);
        st_t e;
        int  t;
        bit  ret;
        bit  cor [NCP];
        @(posedge clk);
        #1;
        reset = rn;
        alloc_req = rq;
        alloc_al_idx = al;
        resolve_valid = rv;
        resolve_al_idx = {a1, a0};
        resolve_correct = rc;
        t = -1;
        for (int k = 0; k < NCP; k++) cor[k] = 0;
        for (int k = 0; k < mq.size(); k++)
            for (int i = 0; i < 2; i++)
                if (rv[i] && mq[k].al == (i == 0 ? a0 : a1)) begin
                    if (rc[i]) cor[k] = 1;
                    else if (t < 0) t = k;
                end
        e.live  = mq.size();
        e.full  = mq.size() == NCP;
        e.busy  = m_busy_left > 0;
        e.rs    = m_rs;
        e.rt    = m_rt;
        e.gnt   = rq && !e.busy && !e.full && t < 0;
        e.tag   = m_tail;
        e.stall = (rq && !e.gnt) || e.busy;
        st_q.push_back(e);
        if (e.gnt) gnt_q.push_back(e.tag);
        if (m_rs) rc_q.push_back(m_rt);
        if (!rn) model_reset();
        else if (t >= 0) begin
            m_tail = mq[t].slot;
            m_rt = mq[t].slot;
            m_rs = 1;
            m_busy_left = 1 + RC;
            for (int k = 0; k < t; k++) if (cor[k]) mq[k].res = 1;
            while (mq.size() > t) mq.delete(mq.size() - 1);
        end else begin
            ret = mq.size() > 0 && mq[0].res;
            for (int k = 0; k < mq.size(); k++) if (cor[k]) mq[k].res = 1;
            if (ret) mq.delete(0);
            if (e.gnt) begin
                mq.push_back('{al, 1'b0, m_tail});
                m_tail = (m_tail + 1) % NCP;
            end
            m_rs = 0;
            if (m_busy_left > 0) m_busy_left--;
        end
    endtask

    task automatic idle(input bit rn);
        step(0, 5'd0, 2'b00, 5'd0, 5'd0, 2'b00, rn);
    endtask

    always @(negedge clk) begin : mon
        st_t e;
        if (st_q.size() > 0) begin
            e = st_q.pop_front();
            chk("alloc_gnt", int'(alloc_gnt), int'(e.gnt));
            chk("int_stall", int'(int_stall), int'(e.stall));
            chk("recover_busy", int'(recover_busy), int'(e.busy));
            chk("cp_full", int'(cp_full), int'(e.full));
            chk("live_count", int'(live_count), e.live);
            chk("recall_start", int'(recall_start), int'(e.rs));
            chk("recall_tag_reg", int'(recall_tag), e.rt);
            if (alloc_gnt) begin
                if (gnt_q.size() == 0) chk("unexpected_grant", 1, 0);
                else chk("alloc_tag", int'(alloc_tag), gnt_q.pop_front());
            end
            if (recall_start) begin
                if (rc_q.size() == 0) chk("unexpected_recall", 1, 0);
                else chk("recall_tag", int'(recall_tag), rc_q.pop_front());
            end
        end
    end

    initial begin
        logic [4:0] a0, a1;
        model_reset();
        idle(0);
        idle(0);
        #1 chk("rst_live", int'(live_count), 0);
        chk("rst_recall", int'(recall_start), 0);
        for (int k = 0; k < 4; k++) begin
            step(1, t1al[k], 2'b00, 5'd0, 5'd0, 2'b00, 1);
            #1 chk("t1_tag", int'(alloc_tag), k);
            chk("t1_gnt", int'(alloc_gnt), 1);
        end
        step(1, 5'd20, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        #1 chk("t1_full", int'(cp_full), 1);
        chk("t1_gnt_blocked", int'(alloc_gnt), 0);
        chk("t1_stall", int'(int_stall), 1);
        step(0, 5'd0, 2'b01, 5'd7, 5'd0, 2'b01, 1);
        step(0, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1);
        idle(1);
        #1 chk("t2_live4", int'(live_count), 4);
        idle(1);
        #1 chk("t2_live3", int'(live_count), 3);
        idle(1);
        #1 chk("t2_live2", int'(live_count), 2);
        step(0, 5'd0, 2'b01, 5'd9, 5'd0, 2'b00, 1);
        idle(1);
        #1 chk("t3_recall", int'(recall_start), 1);
        chk("t3_tag", int'(recall_tag), 2);
        chk("t3_live", int'(live_count), 0);
        chk("t3_busy", int'(recover_busy), 1);
        idle(1);
        idle(1);
        #1 chk("t3_busy3", int'(recover_busy), 1);
        step(1, 5'd5, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        #1 chk("t3_regrant", int'(alloc_gnt), 1);
        chk("t3_regrant_tag", int'(alloc_tag), 2);
        idle(0);
        for (int k = 1; k <= 4; k++) step(1, 5'(k), 2'b00, 5'd0, 5'd0, 2'b00, 1);
        step(0, 5'd0, 2'b11, 5'd4, 5'd2, 2'b00, 1);
        idle(1);
        #1 chk("t4_tag", int'(recall_tag), 1);
        chk("t4_live", int'(live_count), 1);
        idle(0);
        for (int k = 1; k <= 3; k++) step(1, 5'(k), 2'b00, 5'd0, 5'd0, 2'b00, 1);
        step(0, 5'd0, 2'b11, 5'd1, 5'd2, 2'b11, 1);
        step(0, 5'd0, 2'b01, 5'd3, 5'd0, 2'b01, 1);
        idle(1);
        idle(1);
        step(1, 5'd5, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        #1 chk("t5_tag3", int'(alloc_tag), 3);
        step(1, 5'd6, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        step(0, 5'd0, 2'b11, 5'd6, 5'd5, 2'b00, 1);
        idle(1);
        #1 chk("t5_tag", int'(recall_tag), 3);
        chk("t5_live", int'(live_count), 0);
        idle(1);
        idle(1);
        step(1, 5'd8, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        #1 chk("t5_tail", int'(alloc_tag), 3);
        step(1, 5'd10, 2'b00, 5'd0, 5'd0, 2'b00, 1);
        step(1, 5'd11, 2'b01, 5'd8, 5'd0, 2'b00, 1);
        #1 chk("t6_gnt_blocked", int'(alloc_gnt), 0);
        idle(1);
        idle(0);
        idle(1);
        #1 chk("t6_live", int'(live_count), 0);
        chk("t6_busy", int'(recover_busy), 0);
        chk("t6_recall", int'(recall_start), 0);
        chk("t6_tag", int'(recall_tag), 0);
        chk("t6_full", int'(cp_full), 0);
        for (int n = 0; n < 3000; n++) begin
            a0 = 5'($urandom);
            a1 = 5'($urandom);
            if (mq.size() > 0 && $urandom % 4 != 0) a0 = mq[$urandom % mq.size()].al;
            if (mq.size() > 0 && $urandom % 4 != 0) a1 = mq[$urandom % mq.size()].al;
            step($urandom % 10 < 6, 5'($urandom), 2'($urandom), a0, a1,
                 {$urandom % 5 != 0, $urandom % 5 != 0}, $urandom % 200 != 0);
        end
        idle(1);
        @(negedge clk);
        #1 chk("status_drained", st_q.size(), 0);
        chk("grants_drained", gnt_q.size(), 0);
        chk("recalls_drained", rc_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
